// File: rtl/neighborhood_reader_if.sv
// Bundle between neighborhood_reader and its environment: request, shared BRAM read
// port and the streamed neighbourhood outputs. The slave modport is the reader itself.
interface neighborhood_reader_if #(
  parameter int unsigned BIT_DEPTH  = 9,
  parameter int unsigned DIMENSION  = 16,
  parameter int unsigned NUM_LAYERS = 3
);
  localparam int unsigned ADDR_W = $clog2(DIMENSION * DIMENSION);
  localparam int unsigned CW     = $clog2(DIMENSION);
  localparam int unsigned DW     = NUM_LAYERS * BIT_DEPTH;

  logic              start;
  logic [CW-1:0]     x;
  logic [CW-1:0]     y;
  logic [ADDR_W-1:0] bram_addr;
  logic [DW-1:0]     bram_data;
  logic              nbr_valid;
  logic [3:0]        nbr_idx;
  logic [DW-1:0]     nbr_data;
  logic              nbr_edge;
  logic              busy;
  logic              done;
  logic              is_max;
  logic              is_min;

  modport master (
    output start, x, y, bram_data,
    input  bram_addr, nbr_valid, nbr_idx, nbr_data, nbr_edge, busy, done, is_max, is_min
  );

  modport slave (
    input  start, x, y, bram_data,
    output bram_addr, nbr_valid, nbr_idx, nbr_data, nbr_edge, busy, done, is_max, is_min
  );
endinterface

// File: rtl/neighborhood_reader.sv
// Fetches the 3x3 neighbourhood of (x,y) from NUM_LAYERS DoG BRAMs sharing one address,
// streaming one position per cycle (centre first) with edge clamping.
// Optional 26-neighbour extrema compare is built when EXTREMA_CMP_EN is defined.
module neighborhood_reader #(
  parameter int unsigned BIT_DEPTH    = 9,
  parameter int unsigned DIMENSION    = 16,
  parameter int unsigned NUM_LAYERS   = 3,
  parameter int unsigned READ_LATENCY = 2
) (
  input logic                clk,
  input logic                rst_in,
  neighborhood_reader_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(DIMENSION * DIMENSION);
  localparam int unsigned CW     = $clog2(DIMENSION);
  localparam int unsigned DW     = NUM_LAYERS * BIT_DEPTH;
  localparam int unsigned RL     = READ_LATENCY;
  localparam int unsigned CNT_W  = ($clog2(RL + 1) > 4) ? $clog2(RL + 1) : 4;
  localparam logic [CW-1:0] CMAX = CW'(DIMENSION - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [CW-1:0]     r_cx, r_cy;
  logic [ADDR_W-1:0] r_addr;
  logic              w_accept, w_issue;
  logic [3:0]        w_k, w_idx;
  logic [1:0]        w_row, w_col;
  logic [CW-1:0]     w_in_x, w_in_y, w_bx, w_by, w_nx, w_ny;
  logic              w_ex, w_ey, w_edge;
  logic [ADDR_W-1:0] w_addr;

  // Sideband at the address stage, then READ_LATENCY stages to meet bram_data.
  logic                  r_a_vld, r_a_edge, r_a_last;
  logic [3:0]            r_a_idx;
  logic [RL-1:0]         r_sr_vld, r_sr_edge, r_sr_last;
  logic [RL-1:0][3:0]    r_sr_idx;
  logic                  w_tap_vld, w_tap_last;
  logic [3:0]            w_tap_idx;

  logic              r_nbr_valid, r_nbr_edge, r_done;
  logic [3:0]        r_nbr_idx;
  logic [DW-1:0]     r_nbr_data;

  // Clamp one axis of a neighbour: d=0 is -1, d=1 is 0, d=2 is +1. Returns {edge, coord}.
  function automatic logic [CW:0] nbr_axis(input logic [CW-1:0] c, input logic [1:0] d);
    logic [CW:0] r;
    case (d)
      2'd0:    r = (c == '0)   ? {1'b1, c} : {1'b0, c - CW'(1)};
      2'd2:    r = (c == CMAX) ? {1'b1, c} : {1'b0, c + CW'(1)};
      default: r = {1'b0, c};
    endcase
    return r;
  endfunction

  assign w_in_x = (bus.x > CMAX) ? CMAX : bus.x;
  assign w_in_y = (bus.y > CMAX) ? CMAX : bus.y;

  // Next state and which issue slot k (if any) gets registered onto bram_addr.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_k          = 4'd0;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_next = StIssue;
          w_cnt_next   = '0;
          w_accept     = 1'b1;
          w_issue      = 1'b1;
        end
      end
      StIssue: begin
        // r_cnt is the slot currently on bram_addr
        if (r_cnt == CNT_W'(8)) begin
          w_state_next = StDrain;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
          w_issue    = 1'b1;
          w_k        = r_cnt[3:0] + 4'd1;
        end
      end
      StDrain: begin
        if (r_cnt == CNT_W'(RL)) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Slot k to raster index: centre first, then 0,1,2,3,5,6,7,8; then split into row/col.
  always_comb begin
    if (w_k == 4'd0)      w_idx = 4'd4;
    else if (w_k <= 4'd4) w_idx = w_k - 4'd1;
    else                  w_idx = w_k;
    case (w_idx)
      4'd0, 4'd1, 4'd2: w_row = 2'd0;
      4'd3, 4'd4, 4'd5: w_row = 2'd1;
      default:          w_row = 2'd2;
    endcase
    case (w_idx)
      4'd0, 4'd3, 4'd6: w_col = 2'd0;
      4'd1, 4'd4, 4'd7: w_col = 2'd1;
      default:          w_col = 2'd2;
    endcase
  end

  // Clamped neighbour coordinate and its linear address.
  always_comb begin
    w_bx = w_accept ? w_in_x : r_cx;
    w_by = w_accept ? w_in_y : r_cy;
    {w_ex, w_nx} = nbr_axis(w_bx, w_col);
    {w_ey, w_ny} = nbr_axis(w_by, w_row);
    w_edge = w_ex | w_ey;
    w_addr = ADDR_W'(w_ny) * ADDR_W'(DIMENSION) + ADDR_W'(w_nx);
  end

  // FSM state, latched centre, address register and address-stage sideband.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_addr   <= '0;
      r_a_vld  <= 1'b0;
      r_a_edge <= 1'b0;
      r_a_last <= 1'b0;
      r_a_idx  <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_cx <= w_in_x;
        r_cy <= w_in_y;
      end
      if (w_issue) r_addr <= w_addr;
      r_a_vld  <= w_issue;
      r_a_edge <= w_issue & w_edge;
      r_a_last <= w_issue && (w_k == 4'd8);
      r_a_idx  <= w_issue ? w_idx : 4'd0;
    end
  end

  // Latency shift register aligning sideband with returning bram_data.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_sr_vld  <= '0;
      r_sr_edge <= '0;
      r_sr_last <= '0;
      r_sr_idx  <= '0;
    end else begin
      r_sr_vld[0]  <= r_a_vld;
      r_sr_edge[0] <= r_a_edge;
      r_sr_last[0] <= r_a_last;
      r_sr_idx[0]  <= r_a_idx;
      for (int i = 1; i < int'(RL); i++) begin
        r_sr_vld[i]  <= r_sr_vld[i-1];
        r_sr_edge[i] <= r_sr_edge[i-1];
        r_sr_last[i] <= r_sr_last[i-1];
        r_sr_idx[i]  <= r_sr_idx[i-1];
      end
    end
  end

  assign w_tap_vld  = r_sr_vld[RL-1];
  assign w_tap_last = r_sr_last[RL-1];
  assign w_tap_idx  = r_sr_idx[RL-1];

  // Output register: capture BRAM data with its sideband; done rides with the last sample.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_nbr_valid <= 1'b0;
      r_nbr_edge  <= 1'b0;
      r_nbr_idx   <= 4'd0;
      r_nbr_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_nbr_valid <= w_tap_vld;
      r_done      <= w_tap_vld & w_tap_last;
      if (w_tap_vld) begin
        r_nbr_edge <= r_sr_edge[RL-1];
        r_nbr_idx  <= w_tap_idx;
        r_nbr_data <= bus.bram_data;
      end
    end
  end

  assign bus.bram_addr = r_addr;
  assign bus.nbr_valid = r_nbr_valid;
  assign bus.nbr_idx   = r_nbr_idx;
  assign bus.nbr_data  = r_nbr_data;
  assign bus.nbr_edge  = r_nbr_edge;
  assign bus.busy      = (r_state != StIdle);
  assign bus.done      = r_done;

`ifdef EXTREMA_CMP_EN
  localparam int unsigned MID = NUM_LAYERS / 2;

  logic signed [BIT_DEPTH-1:0] r_ctr, w_ref, w_s;
  logic r_run_max, r_run_min, r_is_max, r_is_min;
  logic w_first, w_gt_all, w_lt_all, w_max_next, w_min_next;

  // The centre arrives first (idx 4 only occurs at slot 0).
  assign w_first = w_tap_vld && (w_tap_idx == 4'd4);

  // Compare every sample this cycle against the centre, skipping the centre itself.
  always_comb begin
    w_ref    = w_first ? $signed(bus.bram_data[MID*BIT_DEPTH +: BIT_DEPTH]) : r_ctr;
    w_gt_all = 1'b1;
    w_lt_all = 1'b1;
    w_s      = '0;
    for (int l = 0; l < int'(NUM_LAYERS); l++) begin
      w_s = $signed(bus.bram_data[l*BIT_DEPTH +: BIT_DEPTH]);
      if (!(w_first && (l == int'(MID)))) begin
        w_gt_all = w_gt_all & (w_ref > w_s);
        w_lt_all = w_lt_all & (w_ref < w_s);
      end
    end
    w_max_next = w_first ? w_gt_all : (r_run_max & w_gt_all);
    w_min_next = w_first ? w_lt_all : (r_run_min & w_lt_all);
  end

  // Running flags; published with done, cleared on the next acceptance.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_ctr     <= '0;
      r_run_max <= 1'b0;
      r_run_min <= 1'b0;
      r_is_max  <= 1'b0;
      r_is_min  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_is_max <= 1'b0;
        r_is_min <= 1'b0;
      end
      if (w_tap_vld) begin
        if (w_first) r_ctr <= w_ref;
        r_run_max <= w_max_next;
        r_run_min <= w_min_next;
        if (w_tap_last) begin
          r_is_max <= w_max_next;
          r_is_min <= w_min_next;
        end
      end
    end
  end

  assign bus.is_max = r_is_max;
  assign bus.is_min = r_is_min;
`else
  assign bus.is_max = 1'b0;
  assign bus.is_min = 1'b0;
`endif

endmodule

// File: tb/tb_neighborhood_reader.sv
// Directed bench for neighborhood_reader at DIMENSION=4, NUM_LAYERS=3, READ_LATENCY=2.
// BRAM model returns addr+16*layer with two cycles of latency; entries can be overridden.
module tb_neighborhood_reader;
  localparam int BD = 9;
  localparam int D  = 4;
  localparam int NL = 3;
  localparam int RL = 2;
  localparam int CW = 2;
`ifdef EXTREMA_CMP_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_in;
  always #5 clk = ~clk;

  neighborhood_reader_if #(.BIT_DEPTH(BD), .DIMENSION(D), .NUM_LAYERS(NL)) bus ();

  neighborhood_reader #(
    .BIT_DEPTH(BD), .DIMENSION(D), .NUM_LAYERS(NL), .READ_LATENCY(RL)
  ) dut (
    .clk   (clk),
    .rst_in(rst_in),
    .bus   (bus)
  );

  logic signed [BD-1:0] mem [NL][D*D];
  logic [3:0] a1;

  // Two-cycle BRAM: address captured, then data registered.
  always @(posedge clk) begin
    a1 <= bus.bram_addr;
    bus.bram_data <= {mem[2][a1], mem[1][a1], mem[0][a1]};
  end

  int n_chk = 0;
  int n_bad = 0;
  int exp_addr [9];
  bit exp_edge [9];
  int order [9] = '{4, 0, 1, 2, 3, 5, 6, 7, 8};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic init_mem();
    for (int l = 0; l < NL; l++)
      for (int a = 0; a < D*D; a++) mem[l][a] = BD'(a + 16*l);
  endtask

  function automatic logic [31:0] exp_data(input int a);
    return {5'd0, mem[2][a], mem[1][a], mem[0][a]};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, " addr"},  32'(bus.bram_addr), 0);
    chk({tag, " valid"}, 32'(bus.nbr_valid), 0);
    chk({tag, " idx"},   32'(bus.nbr_idx),   0);
    chk({tag, " data"},  32'(bus.nbr_data),  0);
    chk({tag, " edge"},  32'(bus.nbr_edge),  0);
    chk({tag, " busy"},  32'(bus.busy),      0);
    chk({tag, " done"},  32'(bus.done),      0);
    chk({tag, " max"},   32'(bus.is_max),    0);
    chk({tag, " min"},   32'(bus.is_min),    0);
  endtask

  // One full request; exp_addr/exp_edge hold the slot-ordered expectations.
  task automatic run_read(input string nm, input int xi, input int yi, input bit em, input bit en);
    int k;
    @(negedge clk);
    bus.start = 1'b1;
    bus.x = CW'(xi);
    bus.y = CW'(yi);
    for (int c = 1; c <= 11 + RL; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      chk($sformatf("%s busy c%0d", nm, c), 32'(bus.busy), 32'(c <= 10 + RL));
      if (c <= 9) chk($sformatf("%s addr c%0d", nm, c), 32'(bus.bram_addr), exp_addr[c-1]);
      chk($sformatf("%s valid c%0d", nm, c), 32'(bus.nbr_valid),
          32'(c >= 2 + RL && c <= 10 + RL));
      if (c >= 2 + RL && c <= 10 + RL) begin
        k = c - 2 - RL;
        chk($sformatf("%s idx k%0d", nm, k),  32'(bus.nbr_idx),  order[k]);
        chk($sformatf("%s data k%0d", nm, k), 32'(bus.nbr_data), exp_data(exp_addr[k]));
        chk($sformatf("%s edge k%0d", nm, k), 32'(bus.nbr_edge), 32'(exp_edge[k]));
      end
      chk($sformatf("%s done c%0d", nm, c), 32'(bus.done), 32'(c == 10 + RL));
      if (c == 1) begin
        chk({nm, " max clr"}, 32'(bus.is_max), 0);
        chk({nm, " min clr"}, 32'(bus.is_min), 0);
      end
      if (c >= 10 + RL) begin
        chk($sformatf("%s is_max c%0d", nm, c), 32'(bus.is_max), 32'(em & CMP));
        chk($sformatf("%s is_min c%0d", nm, c), 32'(bus.is_min), 32'(en & CMP));
      end
    end
  endtask

  task automatic set_centre11();
    exp_addr = '{5, 0, 1, 2, 4, 6, 8, 9, 10};
    exp_edge = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
  endtask

  initial begin
    bit seen;
    init_mem();
    rst_in = 1'b0;
    bus.start = 1'b0;
    bus.x = '0;
    bus.y = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_in = 1'b1;

    // Interior centre
    set_centre11();
    run_read("c11", 1, 1, 1'b0, 1'b0);

    // Top-left corner: every -1 clamps to 0
    exp_addr = '{0, 0, 0, 1, 0, 1, 4, 4, 5};
    exp_edge = '{0, 1, 1, 1, 1, 0, 1, 0, 0};
    run_read("c00", 0, 0, 1'b0, 1'b0);

    // x=7 truncates to 3 on a 2-bit bus; bottom-right corner, idx 2,5,6,7,8 clamp
    exp_addr = '{15, 10, 11, 11, 14, 15, 14, 15, 15};
    exp_edge = '{0, 0, 0, 1, 0, 1, 1, 1, 1};
    run_read("c73", 7, 3, 1'b0, 1'b0);

    // start held: re-accepted the cycle after each done, ignored while busy
    @(negedge clk);
    bus.start = 1'b1;
    bus.x = 2'd1;
    bus.y = 2'd1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      chk($sformatf("held done c%0d", c), 32'(bus.done), 32'(c == 12 || c == 25));
      chk($sformatf("held busy c%0d", c), 32'(bus.busy), 32'(c != 13 && c != 26));
      if (c == 14) chk("held addr2", 32'(bus.bram_addr), 5);
      if (c == 17) begin
        chk("held valid2", 32'(bus.nbr_valid), 1);
        chk("held idx2", 32'(bus.nbr_idx), 4);
      end
    end
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk("held final done", 32'(seen), 1);
    @(negedge clk);

    // Reset while slot 3 is on the address bus
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    chk("rst pre addr", 32'(bus.bram_addr), 2);
    rst_in = 1'b0;
    #1;
    chk_all_zero("midrst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("midrst done c%0d", c), 32'(bus.done), 0);
    end
    rst_in = 1'b1;
    exp_addr = '{10, 5, 6, 7, 9, 11, 13, 14, 15};
    exp_edge = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_read("c22", 2, 2, 1'b0, 1'b0);

    // Extrema: strict maximum, then a tie-breaking larger neighbour, then a strict minimum
    set_centre11();
    mem[1][5] = 9'sd100;
    run_read("xmax", 1, 1, 1'b1, 1'b0);
    mem[0][0] = 9'sd100;
    run_read("xnomax", 1, 1, 1'b0, 1'b0);
    init_mem();
    mem[1][5] = -9'sd100;
    run_read("xmin", 1, 1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
